// File: rtl/fp_to_int.sv
// fp_to_int: IEEE-754 single-precision to signed 32-bit integer converter.
// The operand is classified when it is accepted. Its mantissa is then aligned
// by a shifter that moves one bit per cycle, rounded, given its sign and
// returned over a valid/ready handshake.
// Build option: define FP_TO_INT_ROUND_NEAREST_EN to round to nearest with
// ties to even. When the macro is undefined the block truncates toward zero.
// Latency is the same in both builds.

module fp_to_int (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        overflow,
  output logic        underflow,
  output logic        exception
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Saturation value for a given sign.
  function automatic logic [31:0] sat_value(input logic sign);
    return sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;

  // Latched operand and alignment state
  logic        sign_r;
  logic        left_r;
  logic        special_r;
  logic [31:0] spec_data_r;
  logic        spec_ovf_r;
  logic        spec_exc_r;
  logic [31:0] mag_r;
  logic        guard_r;
  logic        sticky_r;
  logic [4:0]  cnt_r;

  // Registered outputs
  logic        out_valid_r;
  logic [31:0] out_data_r;
  logic        overflow_r;
  logic        underflow_r;
  logic        exception_r;

  // Decode of the incoming operand
  logic [7:0]  exp_s;
  logic [22:0] frac_s;
  logic [23:0] mant_s;
  logic        dec_special_s;
  logic [31:0] dec_data_s;
  logic        dec_ovf_s;
  logic        dec_exc_s;
  logic        dec_left_s;
  logic [4:0]  dec_cnt_s;

  logic        accept_s;
  logic        hs_s;

  // Rounding and final result
  logic        round_inc_s;
  logic [31:0] rmag_s;
  logic [31:0] res_s;
  logic [31:0] fin_data_s;
  logic        fin_ovf_s;
  logic        fin_unf_s;
  logic        fin_exc_s;

  assign exp_s  = in_data[30:23];
  assign frac_s = in_data[22:0];
  assign mant_s = {(|exp_s), frac_s};

  // in_ready stays combinational so that it reads 0 while reset is high and
  // reads 1 in the first cycle after reset drops.
  assign in_ready = (state_r == ST_IDLE) && !reset;
  assign accept_s = in_valid && in_ready;
  assign hs_s     = (state_r == ST_OUT) && out_valid_r && out_ready;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign exception = exception_r;

  // Classify the incoming operand: special result, or shift direction and count
  always_comb begin
    dec_special_s = 1'b0;
    dec_data_s    = 32'd0;
    dec_ovf_s     = 1'b0;
    dec_exc_s     = 1'b0;
    dec_left_s    = 1'b0;
    dec_cnt_s     = 5'd0;
    if (exp_s == 8'd255) begin
      dec_special_s = 1'b1;
      dec_exc_s     = 1'b1;
      dec_data_s    = sat_value(in_data[31]);
    end else if (exp_s >= 8'd158) begin
      dec_special_s = 1'b1;
      if (in_data[31] && (exp_s == 8'd158) && (frac_s == 23'd0)) begin
        dec_data_s = 32'h8000_0000;
      end else begin
        dec_ovf_s  = 1'b1;
        dec_data_s = sat_value(in_data[31]);
      end
    end else if ((exp_s == 8'd0) && (frac_s == 23'd0)) begin
      dec_special_s = 1'b1;
    end else if (exp_s >= 8'd150) begin
      // 150..157 share upper bits, so E-150 is the low five bits minus 22
      dec_left_s = 1'b1;
      dec_cnt_s  = exp_s[4:0] - 5'd22;
    end else begin
      // 150-E is 1..24 for E in 126..149; modulo-32 arithmetic on the low
      // five bits gives it exactly. Smaller exponents saturate at 25.
      if (exp_s <= 8'd125) begin
        dec_cnt_s = 5'd25;
      end else begin
        dec_cnt_s = 5'd22 - exp_s[4:0];
      end
    end
  end

  // Next-state logic of the control FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (dec_special_s || (dec_cnt_s == 5'd0)) begin
            state_nxt_s = ST_ROUND;
          end else begin
            state_nxt_s = ST_ALIGN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (cnt_r <= 5'd1) begin
          state_nxt_s = ST_ROUND;
        end else begin
          state_nxt_s = ST_ALIGN;
        end
      end
      ST_ROUND: state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch and the one-bit-per-cycle alignment shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_r      <= 1'b0;
      left_r      <= 1'b0;
      special_r   <= 1'b0;
      spec_data_r <= 32'd0;
      spec_ovf_r  <= 1'b0;
      spec_exc_r  <= 1'b0;
      mag_r       <= 32'd0;
      guard_r     <= 1'b0;
      sticky_r    <= 1'b0;
      cnt_r       <= 5'd0;
    end else if (accept_s) begin
      sign_r      <= in_data[31];
      left_r      <= dec_left_s;
      special_r   <= dec_special_s;
      spec_data_r <= dec_data_s;
      spec_ovf_r  <= dec_ovf_s;
      spec_exc_r  <= dec_exc_s;
      mag_r       <= {8'd0, mant_s};
      guard_r     <= 1'b0;
      sticky_r    <= 1'b0;
      cnt_r       <= dec_special_s ? 5'd0 : dec_cnt_s;
    end else if (state_r == ST_ALIGN) begin
      cnt_r <= cnt_r - 5'd1;
      if (left_r) begin
        mag_r <= {mag_r[30:0], 1'b0};
      end else begin
        guard_r  <= mag_r[0];
        sticky_r <= sticky_r | guard_r;
        mag_r    <= {1'b0, mag_r[31:1]};
      end
    end
  end

  // Rounding, sign application and flag selection for the aligned operand
  always_comb begin
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    round_inc_s = guard_r & (sticky_r | mag_r[0]);
`else
    round_inc_s = 1'b0;
`endif
    rmag_s = mag_r + {31'd0, round_inc_s};
    if (sign_r) begin
      res_s = ~rmag_s + 32'd1;
    end else begin
      res_s = rmag_s;
    end
    if (special_r) begin
      fin_data_s = spec_data_r;
      fin_ovf_s  = spec_ovf_r;
      fin_exc_s  = spec_exc_r;
      fin_unf_s  = 1'b0;
    end else begin
      // Zero inputs were classified as special, so this operand is nonzero
      fin_data_s = res_s;
      fin_ovf_s  = 1'b0;
      fin_exc_s  = 1'b0;
      fin_unf_s  = (res_s == 32'd0);
    end
  end

  // Output registers: loaded in ROUND, valid in OUT, cleared on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      exception_r <= 1'b0;
    end else if (state_r == ST_ROUND) begin
      out_valid_r <= 1'b0;
      out_data_r  <= fin_data_s;
      overflow_r  <= fin_ovf_s;
      underflow_r <= fin_unf_s;
      exception_r <= fin_exc_s;
    end else if (hs_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      exception_r <= 1'b0;
    end else if (state_r == ST_OUT) begin
      out_valid_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int. The reference model computes the
// conversion with plain 64-bit integer arithmetic. A per-cycle compare step
// checks every valid output, the first-valid latency and in_ready.

module tb_fp_to_int;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        overflow;
  logic        underflow;
  logic        exception;

  fp_to_int dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .underflow (underflow),
    .exception (exception)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  // Count rising edges so that latency can be measured
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  // Expected results, indexed in issue order
  logic [31:0] exp_data [0:1023];
  logic [2:0]  exp_fl   [0:1023];
  int          exp_lat  [0:1023];
  int          exp_acc  [0:1023];
  int          wr_idx = 0;
  int          rd_idx = 0;
  bit          seen   = 1'b0;
  int          rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion. Flags are returned as {overflow, underflow, exception}.
  task automatic model(input logic [31:0] d, output logic [31:0] r, output logic [2:0] fl, output int n);
    int     e;
    int     s;
    longint m, mag, q, rem, half, v;
    bit     up;
    e  = int'(d[30:23]);
    m  = {40'd0, (d[30:23] != 8'd0), d[22:0]};
    fl = 3'b000;
    n  = 0;
    r  = 32'd0;
    if (e == 255) begin
      r  = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      fl = 3'b001;
    end else begin
      if (e >= 160) begin
        mag = 64'h1_0000_0000;
      end else if (e >= 150) begin
        mag = m << (e - 150);
      end else begin
        s = 150 - e;
        if (s >= 40) begin
          q    = 0;
          rem  = m;
          half = 64'h1 << 39;
        end else begin
          q    = m >> s;
          rem  = m - (q << s);
          half = 64'h1 << (s - 1);
        end
`ifdef FP_TO_INT_ROUND_NEAREST_EN
        up = (rem > half) || ((rem == half) && q[0]);
`else
        up = 1'b0;
`endif
        mag = q + longint'(up);
      end
      v = d[31] ? -mag : mag;
      if ((v > 64'sd2147483647) || (v < -64'sd2147483648)) begin
        r  = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        fl = 3'b100;
      end else begin
        r = v[31:0];
        if ((d[30:0] != 31'd0) && (r == 32'd0)) fl = 3'b010;
        if ((d[30:0] == 31'd0) || (e >= 158)) n = 0;
        else if (e >= 150) n = e - 150;
        else n = (150 - e > 25) ? 25 : 150 - e;
      end
    end
  endtask

  // Per-cycle compare step, sampled on the falling edge
  task automatic cycle_check();
    if (reset) begin
      rd_idx = wr_idx;
      seen   = 1'b0;
    end else begin
      if (rd_idx != wr_idx) check("busy_in_ready", 32'(in_ready), 32'd0);
      if (out_valid) begin
        if (rd_idx == wr_idx) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("out_data", out_data, exp_data[rd_idx]);
          check("out_flags", 32'({overflow, underflow, exception}), 32'(exp_fl[rd_idx]));
          if (!seen) begin
            check("latency", 32'(cyc - exp_acc[rd_idx]), 32'(exp_lat[rd_idx]));
            seen = 1'b1;
          end
          if (out_ready) begin
            rd_idx++;
            seen = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic apply(input logic [31:0] d);
    int t;
    int n;
    t = 0;
    while (!in_ready && t < 400) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      model(d, exp_data[wr_idx], exp_fl[wr_idx], n);
      exp_lat[wr_idx] = n + 2;
      exp_acc[wr_idx] = cyc + 1;
      tick();
      in_valid = 1'b0;
      wr_idx++;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (rd_idx != wr_idx && t < 3000) begin
      tick();
      t++;
    end
    check("drain", 32'(rd_idx), 32'(wr_idx));
  endtask

  // Check the model against a hand-computed result, then run the operand through the DUT
  task automatic directed(input logic [31:0] d, input logic [31:0] r, input logic [2:0] fl, input int lat);
    logic [31:0] mr;
    logic [2:0]  mf;
    int          mn;
    model(d, mr, mf, mn);
    check("model_data", mr, r);
    check("model_flags", 32'(mf), 32'(fl));
    check("model_latency", 32'(mn + 2), 32'(lat));
    apply(d);
    wait_done();
  endtask

  logic [31:0] held_d;
  logic [2:0]  held_f;
  logic [31:0] rnd;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_flags", 32'({overflow, underflow, exception}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    directed(32'h40490FDB, 32'd3,          3'b000, 24);
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    directed(32'hC02CCCCD, 32'hFFFF_FFFD,  3'b000, 24);
    directed(32'h3FC00000, 32'd2,          3'b000, 25);
    directed(32'hBF400000, 32'hFFFF_FFFF,  3'b000, 26);
`else
    directed(32'hC02CCCCD, 32'hFFFF_FFFE,  3'b000, 24);
    directed(32'h3FC00000, 32'd1,          3'b000, 25);
    directed(32'hBF400000, 32'd0,          3'b010, 26);
`endif
    directed(32'h40200000, 32'd2,          3'b000, 24);
    directed(32'h3F000000, 32'd0,          3'b010, 26);
    directed(32'h00000001, 32'd0,          3'b010, 27);
    directed(32'h4F000000, 32'h7FFF_FFFF,  3'b100, 2);
    directed(32'h4F800000, 32'h7FFF_FFFF,  3'b100, 2);
    directed(32'hCF000000, 32'h8000_0000,  3'b000, 2);
    directed(32'h7F800000, 32'h7FFF_FFFF,  3'b001, 2);
    directed(32'hFF800001, 32'h8000_0000,  3'b001, 2);
    directed(32'h00000000, 32'd0,          3'b000, 2);
    directed(32'h80000000, 32'd0,          3'b000, 2);
    directed(32'h4B000001, 32'h0080_0001,  3'b000, 2);
    directed(32'hCEFFFFFF, 32'h8000_0080,  3'b000, 9);

    // Backpressure: hold out_ready low for five cycles in OUT
    rdy_mode  = 2;
    out_ready = 1'b0;
    apply(32'hC02CCCCD);
    for (int t = 0; t < 100 && !out_valid; t++) tick();
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    held_d = out_data;
    held_f = {overflow, underflow, exception};
    repeat (5) tick();
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data", out_data, held_d);
    check("bp_hold_flags", 32'({overflow, underflow, exception}), 32'(held_f));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    rdy_mode  = 0;
    out_ready = 1'b1;
    wait_done();

    // Reset in the middle of alignment
    apply(32'h00000001);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data", out_data, 32'd0);
    check("midreset_flags", 32'({overflow, underflow, exception}), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("midreset_in_ready_after", 32'(in_ready), 32'd1);
    apply(32'h3FC00000);
    wait_done();

    // Randomised operands, first with random backpressure, then back-to-back
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      rnd = $urandom;
      if ($urandom_range(0, 3) != 0) rnd[30:23] = 8'($urandom_range(118, 160));
      if ($urandom_range(0, 15) == 0) rnd[30:23] = 8'd0;
      if ($urandom_range(0, 15) == 0) rnd[30:23] = 8'd255;
      apply(rnd);
    end
    wait_done();
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      rnd = $urandom;
      rnd[30:23] = 8'($urandom_range(124, 159));
      apply(rnd);
    end
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
